// File: rtl/note_pkg.sv
// Shared types and constants for the guitar-mode playback engine.
// Combinational helpers only; no latency.
// No flow control; pure functions and typedefs.
package note_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bits 29:0 of a note word are a one-hot-ish string/fret map.
    localparam int NOTE_BITS = 30;

    typedef struct packed {
        logic       valid;
        logic [2:0] str;
        logic [2:0] fret;
    } note_t;

    // Bit i = 5*f + s. f = 0..4 is fret f+1, f = 5 is the open string.
    // Scanning from the top down lets the lowest set bit overwrite the rest.
    function automatic note_t decode_note(input logic [31:0] word);
        note_t n;
        n = '0;
        for (int f = 5; f >= 0; f--) begin
            for (int s = 4; s >= 0; s--) begin
                if (word[5*f + s]) begin
                    n.valid = 1'b1;
                    n.str   = 3'(s);
                    n.fret  = (f == 5) ? 3'd0 : 3'(f + 1);
                end
            end
        end
        return n;
    endfunction

    // Half-period in 50 MHz cycles for tone index k = 6*string + fret.
    // Entries are semitone steps up from 220 Hz.
    function automatic logic [17:0] half_period_of(input logic [2:0] str,
                                                   input logic [2:0] fret);
        int k;
        logic [17:0] hp;
        k = 6 * int'(str) + int'(fret);
        case (k)
            0:       hp = 18'd113636;
            1:       hp = 18'd107258;
            2:       hp = 18'd101238;
            3:       hp = 18'd95556;
            4:       hp = 18'd90193;
            5:       hp = 18'd85131;
            6:       hp = 18'd80353;
            7:       hp = 18'd75843;
            8:       hp = 18'd71586;
            9:       hp = 18'd67569;
            10:      hp = 18'd63776;
            11:      hp = 18'd60197;
            12:      hp = 18'd56818;
            13:      hp = 18'd53629;
            14:      hp = 18'd50619;
            15:      hp = 18'd47778;
            16:      hp = 18'd45097;
            17:      hp = 18'd42566;
            18:      hp = 18'd40177;
            19:      hp = 18'd37922;
            20:      hp = 18'd35793;
            21:      hp = 18'd33784;
            22:      hp = 18'd31888;
            23:      hp = 18'd30098;
            24:      hp = 18'd28409;
            25:      hp = 18'd26815;
            26:      hp = 18'd25310;
            27:      hp = 18'd23889;
            28:      hp = 18'd22548;
            29:      hp = 18'd21283;
            default: hp = 18'd0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// Square-wave generator: toggles every half_period cycles while enabled.
// First edge half_period cycles after en rises; output gated by en.
// No backpressure; counter and output clear whenever en is low.
module tone_gen (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [17:0] half_period,
    output logic        tone_out
);

    logic [17:0] cnt_q, cnt_d;
    logic        tone_q, tone_d;

    // Count up to half_period-1, then wrap and flip the output.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!en) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == half_period - 18'd1) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d  = cnt_q + 18'd1;
        end
    end

    // Counter and tone state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    // Gating keeps the output silent the same cycle the note ends.
    assign tone_out = tone_q & en;

endmodule

// File: rtl/note_player.sv
// Plays note RAM words 0..DEPTH-1 one per beat as square-wave tones.
// start to first sounding cycle: 4 cycles (FETCH x2, LOAD, PLAY).
// Beats seen while fetching are held in beat_pending; stop aborts at once.
module note_player
    import note_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     beat,
    input  logic [31:0]              ram_q,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic                     note_valid,
    output logic [2:0]               string_idx,
    output logic [2:0]               fret_idx,
    output logic                     tone_out,
    output logic                     busy,
    output logic                     done
);

    localparam int AW        = $clog2(DEPTH);
    localparam int LAST_ADDR = DEPTH - 1;

    state_t          state_q, state_d;
    logic            fetch_cnt_q, fetch_cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            beat_pend_q, beat_pend_d;
    logic            note_valid_q, note_valid_d;
    logic [2:0]      str_q, str_d;
    logic [2:0]      fret_q, fret_d;
    logic [17:0]     hp_q, hp_d;
    note_t           dec;

    // Decode the RAM word presented during LOAD.
    always_comb begin
        dec = decode_note(ram_q);
    end

    // Sequencing: fetch, load, play until a beat, then next address or done.
    always_comb begin
        state_d      = state_q;
        fetch_cnt_d  = fetch_cnt_q;
        addr_d       = addr_q;
        beat_pend_d  = beat_pend_q;
        note_valid_d = note_valid_q;
        str_d        = str_q;
        fret_d       = fret_q;
        hp_d         = hp_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    addr_d      = '0;
                    fetch_cnt_d = 1'b0;
                    beat_pend_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (beat) begin
                    beat_pend_d = 1'b1;
                end
                if (fetch_cnt_q) begin
                    state_d = ST_LOAD;
                end else begin
                    fetch_cnt_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    beat_pend_d = 1'b1;
                end
                note_valid_d = dec.valid;
                str_d        = dec.str;
                fret_d       = dec.fret;
                hp_d         = half_period_of(dec.str, dec.fret);
                state_d      = ST_PLAY;
            end
            ST_PLAY: begin
                // A held beat is spent here, so a note lasts at least 1 cycle.
                beat_pend_d = 1'b0;
                if (beat || beat_pend_q) begin
                    note_valid_d = 1'b0;
                    if (addr_q == AW'(LAST_ADDR)) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d      = addr_q + AW'(1);
                        fetch_cnt_d = 1'b0;
                        state_d     = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                addr_d       = '0;
                note_valid_d = 1'b0;
                str_d        = '0;
                fret_d       = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // stop overrides everything, including a simultaneous start.
        if (stop) begin
            state_d      = ST_IDLE;
            fetch_cnt_d  = 1'b0;
            addr_d       = '0;
            beat_pend_d  = 1'b0;
            note_valid_d = 1'b0;
            str_d        = '0;
            fret_d       = '0;
        end
    end

    // Control and note registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            fetch_cnt_q  <= 1'b0;
            addr_q       <= '0;
            beat_pend_q  <= 1'b0;
            note_valid_q <= 1'b0;
            str_q        <= '0;
            fret_q       <= '0;
            hp_q         <= '0;
        end else begin
            state_q      <= state_d;
            fetch_cnt_q  <= fetch_cnt_d;
            addr_q       <= addr_d;
            beat_pend_q  <= beat_pend_d;
            note_valid_q <= note_valid_d;
            str_q        <= str_d;
            fret_q       <= fret_d;
            hp_q         <= hp_d;
        end
    end

    // note_valid_q is only ever set while in PLAY, so it doubles as the enable.
    tone_gen u_tone_gen (
        .clk         (clk),
        .resetn      (resetn),
        .en          (note_valid_q),
        .half_period (hp_q),
        .tone_out    (tone_out)
    );

    assign ram_addr   = addr_q;
    assign note_valid = note_valid_q;
    assign string_idx = str_q;
    assign fret_idx   = fret_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Playback engine for guitar mode. It reads 32-bit note words from the 64x32 note RAM that record mode fills, one word per tempo beat, starting at address 0.
- Each word is decoded back into a string/fret position, and a square-wave tone is driven at that note's pitch for one beat.
- Sits beside the recording datapath; shares the RAM read port and the clock divider's beat pulse.

Parameters:
- DEPTH, 64, number of note words; address width is clog2(DEPTH).
- LAST_ADDR, DEPTH-1, final address played before DONE.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin playback from address 0
- stop  in  1  one-cycle pulse: abort playback
- beat  in  1  one-cycle tempo pulse from the clock divider
- ram_q  in  32  RAM read data; registered, 1-cycle latency after ram_addr
- ram_addr  out  6  RAM read address
- note_valid  out  1  high while a decoded non-rest note is sounding
- string_idx  out  3  decoded string 0..4
- fret_idx  out  3  decoded fret 0..5 (0 = open)
- tone_out  out  1  square wave to the audio path
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when LAST_ADDR finishes

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0; beat_pending 0; tone counter 0.
- Note word decode, for bits i = 0..29:
  - i = 5*f + s, with s = string 0..4.
  - f = 0..4 means fret_idx = f+1; f = 5 (bits 25..29) means fret_idx = 0 (open).
  - If several bits are set, the lowest set bit wins.
  - Bits 30 and 31 are ignored.
  - A word with no set bits in 29:0 is a rest: note_valid=0 and tone_out held 0.
- Pitch: tone index k = 6*string_idx + fret_idx, giving 0..29. half_period = HP_TABLE[k]. tone_out toggles each time the counter reaches half_period-1, and the counter then resets to 0.
- State machine:
  - IDLE: outputs 0. start goes to FETCH with ram_addr=0.
  - FETCH: waits exactly 2 cycles (address register plus RAM latency), then goes to LOAD.
  - LOAD: 1 cycle. Latches ram_q, decodes, loads half_period, clears the tone counter, sets tone_out=0, then goes to PLAY.
  - PLAY: sounds the note. On beat, or on beat_pending:
    - if ram_addr == LAST_ADDR, go to DONE;
    - otherwise ram_addr+1 and go to FETCH.
  - DONE: 1 cycle, done=1, then IDLE. Clears note_valid and tone_out.
- beat arriving in FETCH or LOAD sets beat_pending, so no beat is lost. beat_pending is consumed on the first PLAY cycle, giving a minimum note duration of 1 cycle.
- stop in any state: next cycle IDLE, outputs cleared, ram_addr=0.
- start and stop in the same cycle: stop wins. start while busy is ignored.
- Address wraps never occur; playback ends at LAST_ADDR.
- Latency: start to first tone_out edge-capable cycle is 4 cycles (FETCH x2, LOAD, then PLAY).
- string_idx and fret_idx hold their last decoded values until the next LOAD or IDLE.

Decomposition:
- Package note_pkg holds:
  - state enum (IDLE, FETCH, LOAD, PLAY, DONE);
  - NOTE_BITS=30;
  - HP_TABLE[0..29] of 18-bit half-period constants at 50 MHz. Each string's base is one semitone-stepped entry, with HP_TABLE[0]=113636 (220 Hz) and HP_TABLE[1]=107258 (233.08 Hz);
  - the decode function word -> {valid, string, fret}.
- Sub-module tone_gen has inputs clk, resetn, en, half_period[17:0] and output tone_out. It is instantiated once.

Test Plan:
- Reset mid-PLAY: resetn low asynchronously -> all outputs 0 within the same cycle, and state IDLE after release.
- RAM[0]=32'h0000_0001, RAM[1]=32'h0200_0000, start -> sequence at address 0, then 1:
  - address 0: string_idx=0, fret_idx=1, note_valid=1, tone_out period 2*HP_TABLE[1] cycles;
  - address 1 (bit 25): string 0, fret 0, half_period 113636.
- RAM[2]=32'h0000_0000 -> during that beat note_valid=0 and tone_out stays 0 for the whole beat.
- RAM[3]=32'h0000_0041 (bits 0 and 6 set) -> lowest bit wins: string 0, fret 1.
- beat asserted in the FETCH cycle -> the note plays for 1 cycle in PLAY, then ram_addr advances. No beat is dropped over 64 notes: done pulses after exactly 64 beats.
- stop pulsed in PLAY at address 10 -> next cycle busy=0 and ram_addr=0. stop and start in the same cycle -> remains IDLE.
